fifo_rd_arbiter: RTL
====================

# fifo_rd_arbiter

Read-side scheduler for the async FIFO: shares the single FIFO read port (read-pointer/empty logic plus memory read data) among NREQ consumers in the read clock domain. Grants round-robin, bursts up to BURST_LEN words per grant, drives the pop strobe, and presents each word in a one-entry output register with per-consumer valid/ready. Sits between the FIFO read pointer block and downstream read-domain clients.

## Interface
- DSIZE, 8, data word width (matches FIFO memory width)
- NREQ, 4, number of consumers (≥2)
- BURST_LEN, 4, maximum words popped per grant (≥1)
- rclk  in  1  read-domain clock
- rrst  in  1  reset; one clock, reset is synchronous and active-high
- rempty  in  1  registered FIFO empty flag
- rdata  in  DSIZE  FIFO head word (combinational read at current read address)
- rinc  out  1  pop strobe to read pointer logic
- req  in  NREQ  consumer i requests data
- dready  in  NREQ  consumer i accepts dout this cycle
- dvalid  out  NREQ  one-hot: dout valid for consumer i
- dout  out  DSIZE  registered data word
- gnt  out  NREQ  one-hot current grant (zero in IDLE)

## Operation
- Reset: state IDLE, gnt=0, dvalid=0, dout=0, burst count=0, last-grant pointer=NREQ-1 (consumer 0 wins first arbitration). rinc=0.
- States: IDLE, BURST, DRAIN.
- IDLE: if any req, pick first requester scanning last+1, last+2, … mod NREQ; register gnt, last=winner, count=0, go BURST. No req: stay.
- BURST: pop = req[g] & ~rempty & (dvalid==0 | dready[g]); rinc=pop (combinational). On pop: dout<=rdata, dvalid<=onehot(g), count+1. No pop and dready[g]: dvalid<=0.
- BURST exits to DRAIN when: pop makes count==BURST_LEN; or req[g]=0 (no pop that cycle); or rempty=1 with count>0. rempty with count==0: stay, grant held.
- DRAIN: no pops. dvalid clears on dready[g]. When dvalid is 0 after the edge, go IDLE; gnt cleared on entry to IDLE.
- dvalid only ever set for the granted consumer; grant never changes while dvalid is set.
- Count width clog2(BURST_LEN+1); pointer wraps NREQ-1 → 0.

## Timing
- req seen in IDLE at cycle 0 → gnt/BURST at cycle 1 → earliest rinc cycle 1 → dvalid cycle 2.
- Back-to-back pops at one word/cycle when dready held high.
- rempty reflects the pop of the previous cycle (registered from next-pointer compare); no extra guarding.
- Final-pop cycle with dready: data moves, state DRAIN next cycle; IDLE one cycle later if accepted.
- Minimum grant-to-grant turnaround: BURST → DRAIN → IDLE → BURST (2 idle cycles).
- rrst mid-burst: all state to reset values next edge; dout contents discarded; rinc=0 during reset cycle.

## Structure
- Package fifo_rd_arb_pkg: state enum typedef (IDLE, BURST, DRAIN).
- Sub-module rr_pick: combinational round-robin picker (req, last pointer → one-hot winner, index, any).
- Top: FSM, count, output register, rinc decode.

## Test plan
- Reset then req=4'b0001, 6 words queued, dready=1 → 4 pops on cycles 1–4, dvalid[0] cycles 2–5, DRAIN, IDLE; remaining 2 words popped on next grant.
- req=4'b1111 persistently, 16 words → grants in order 0,1,2,3, 4 words each, data order preserved.
- Consumer 1 granted, dready[1]=0 for 3 cycles → one pop only, rinc=0 until acceptance, dout stable.
- FIFO empty, req=4'b0100 → BURST with gnt[2], rinc=0; word written → popped, delivered; subsequent empty with count=1 → DRAIN.
- req[3] drops after 2 pops → DRAIN, no further rinc, dvalid cleared on dready, next arbitration starts at consumer 0.
- rrst asserted during burst with dvalid set → next cycle dvalid=0, gnt=0, rinc=0, IDLE; consumer 0 wins next.

Source files
------------

// File: rtl/fifo_rd_arb_pkg.sv
// rtl/fifo_rd_arb_pkg.sv - shared types for the FIFO read-side arbiter
package fifo_rd_arb_pkg;

  // Scheduler phases: waiting for a requester, popping for the owner, emptying the output register
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// rtl/fifo_rd_arbiter_if.sv - FIFO read port and consumer handshake bundle
interface fifo_rd_arbiter_if #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4
);

  // FIFO read-pointer side
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;

  // Consumer side
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  dready;
  logic [NREQ-1:0]  dvalid;
  logic [DSIZE-1:0] dout;
  logic [NREQ-1:0]  gnt;

  // Arbiter view
  modport master (
    input  rempty, rdata, req, dready,
    output rinc, dvalid, dout, gnt
  );

  // FIFO plus consumers view
  modport slave (
    output rempty, rdata, req, dready,
    input  rinc, dvalid, dout, gnt
  );

endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rtl/fifo_rd_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Scan last+NREQ down to last+1 so the nearest requester after last is written last and wins
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (req[cand]) begin
        win       = '0;
        win[cand] = 1'b1;
        win_idx   = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin burst scheduler for the FIFO read port
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic               rclk,
  input  logic               rrst,
  fifo_rd_arbiter_if.master  bus
);

  localparam int            IW        = $clog2(NREQ);
  localparam int            CW        = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(BURST_LEN);
  localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

  arb_state_t       state, state_nxt;
  logic [NREQ-1:0]  gnt_q, gnt_nxt;
  logic [IW-1:0]    gidx, gidx_nxt;
  logic [IW-1:0]    last, last_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             held, held_nxt;
  logic [DSIZE-1:0] dout_q, dout_nxt;

  logic [NREQ-1:0]  pick_win;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             req_g;
  logic             ready_g;
  logic             pop;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .last    (last),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign req_g   = bus.req[gidx];
  assign ready_g = bus.dready[gidx];

  // A word may be popped only when the output register is free or being emptied this cycle
  assign pop      = (state == BURST) && req_g && !bus.rempty && (!held || ready_g);
  assign bus.rinc = pop && !rrst;

  assign bus.gnt    = gnt_q;
  assign bus.dvalid = held ? gnt_q : '0;
  assign bus.dout   = dout_q;

  // Next-state, grant bookkeeping and output-register load
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    gidx_nxt  = gidx;
    last_nxt  = last;
    count_nxt = count;
    held_nxt  = held;
    dout_nxt  = dout_q;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_nxt   = pick_win;
          gidx_nxt  = pick_idx;
          last_nxt  = pick_idx;
          count_nxt = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (pop) begin
          dout_nxt  = bus.rdata;
          held_nxt  = 1'b1;
          count_nxt = count + CW'(1);
          if (count_nxt == COUNT_MAX) begin
            state_nxt = DRAIN;
          end
        end else begin
          if (ready_g) begin
            held_nxt = 1'b0;
          end
          // An empty FIFO before the first word keeps the grant waiting for data
          if (!req_g || (bus.rempty && count != '0)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (ready_g) begin
          held_nxt = 1'b0;
        end
        if (!held_nxt) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        held_nxt  = 1'b0;
      end
    endcase
  end

  // State register; reset discards any held word and rewinds the pointer so consumer 0 wins first
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state  <= IDLE;
      gnt_q  <= '0;
      gidx   <= '0;
      last   <= LAST_RST;
      count  <= '0;
      held   <= 1'b0;
      dout_q <= '0;
    end else begin
      state  <= state_nxt;
      gnt_q  <= gnt_nxt;
      gidx   <= gidx_nxt;
      last   <= last_nxt;
      count  <= count_nxt;
      held   <= held_nxt;
      dout_q <= dout_nxt;
    end
  end

endmodule
